uart_receiver: RTL and testbench
================================

# uart_receiver

Serial 8N1 receiver. It is the receive-side counterpart of the UART transmitter that the hardware RNG core uses to send random bytes. It recovers bytes from an asynchronous `uart_rx` line using a bit-period counter and presents each byte as a one-cycle strobe. Typical uses are board-level loopback checks of the RNG output stream and a future host command channel into the design.

## Interface
- `comm_clk_frequency`, 50_000_000 — clk frequency in Hz.
- `baud_rate`, 115_200 — line rate in bit/s.
- Derived, not overridable: `CYCLES = comm_clk_frequency / baud_rate` (integer truncation) and `HALF = CYCLES / 2`. Elaboration fails if `CYCLES < 4`.

Ports:
- `clk` input 1 — single clock; all logic is on posedge.
- `reset` input 1 — synchronous, active-low. When low at a posedge, all state is reset.
- `uart_rx` input 1 — asynchronous serial line; idles high.
- `rx_byte` output 8 — last correctly framed byte. Reset value 0x00.
- `rx_new_byte` output 1 — one-cycle pulse when `rx_byte` has just updated. Reset value 0.
- `rx_frame_error` output 1 — one-cycle pulse when the stop bit is sampled low. Reset value 0.
- `rx_idle` output 1 — high in IDLE. Reset value 1.

## Operation
- **Synchronizer:** two flops, both reset to 1. `rx_s` is the second flop.
- **Armed flag:** cleared by reset and set on the first cycle with `rx_s==1`. A start bit is accepted only when armed, so no byte is decoded from a frame already in progress at reset release.
- **Bit value:** `rx_v = rx_s`, or the majority value when the majority feature is enabled (see Configuration).
- **States:** IDLE, START, DATA, STOP, BREAK. Counter `cnt` is 16 bits or wider. Bit index is 3 bits.
  - **IDLE:** if armed and `rx_s==0`, set `cnt<=0` and go to START.
  - **START:** `cnt` increments. At `cnt==HALF-1`:
    - `rx_v==0`: go to DATA with `cnt<=0` and index 0.
    - `rx_v==1`: glitch; return to IDLE with no output.
  - **DATA:** at `cnt==CYCLES-1`, shift `rx_v` into the shift register LSB-first and set `cnt<=0`. After the bit with index 7, go to STOP.
  - **STOP:** at `cnt==CYCLES-1`:
    - `rx_v==1`: `rx_byte<=shift`, pulse `rx_new_byte`, go to IDLE.
    - `rx_v==0`: pulse `rx_frame_error`, leave `rx_byte` unchanged, go to BREAK.
  - **BREAK:** stay until `rx_s==1`, then go to IDLE.
- `rx_new_byte` and `rx_frame_error` never assert in the same cycle.
- No flow control and no buffering. A consumer that misses the strobe loses the byte; `rx_byte` holds it until the next good frame.
- **Reset mid-frame:**
  - State returns to IDLE, outputs return to their reset values, and the partial byte is discarded.
  - Armed is cleared, so a line still low at reset release produces neither a byte nor an error until the line has been seen high.

## Timing
- Let Ep be the posedge at which the first synchronizer flop captures the falling start edge. IDLE detects the start at Ep+2.
- START decision at Ep+2+HALF.
- Data bit i (0..7) sampled at Ep+2+HALF+(i+1)·CYCLES.
- Stop decision at Ep+2+HALF+9·CYCLES. `rx_new_byte`, `rx_frame_error` and `rx_byte` are registered at that edge and are valid for the following cycle.
- `rx_idle` falls one cycle after detection and rises one cycle after the stop decision (good frame) or after BREAK exit.
- Back-to-back frames are supported. IDLE can detect the next start edge in the cycle immediately after the stop decision.
- Sampling-point error is at most ±1 cycle plus the truncation error of `CYCLES`.

## Configuration
- Macro: `UART_RX_MAJORITY_EN`.
- **Defined:**
  - A 3-bit history holds the last three `rx_s` values, reset to 3'b111.
  - `rx_v` is the majority of the history, evaluated at the same decision edges.
  - A single-cycle glitch at a sample point is rejected.
  - Decision latency is unchanged.
- **Undefined:** `rx_v = rx_s`, and the history register is not built.
- IDLE start detection always uses raw `rx_s` in both builds.

## Test plan
All scenarios use `comm_clk_frequency=1_600_000`, `baud_rate=100_000`, giving CYCLES=16 and HALF=8.
- **Single byte:** send 0xA5 8N1 → one `rx_new_byte` pulse registered at Ep+154; `rx_byte`=0xA5; `rx_frame_error` stays 0.
- **Back-to-back:** send 0x00 then 0xFF with no idle gap → two pulses 160 cycles apart; values 0x00 and 0xFF.
- **Framing error:**
  - Send 0x3C with the stop bit driven low → `rx_frame_error` pulses at Ep+154, no `rx_new_byte`, `rx_byte` keeps its prior value.
  - Hold the line low for 50 more cycles → `rx_idle` stays 0.
  - Release the line, then send 0x55 → `rx_byte`=0x55.
- **Glitch rejection:** 4-cycle low pulse on an idle line → START rejects at Ep+10, `rx_idle` returns to 1, no strobes.
- **Reset mid-frame:**
  - Pull `reset` low during bit 4 and release it while the line is low → no strobes until the line returns high.
  - A following 0x81 frame → received correctly.
- **Majority feature:** send 0x00 with a 1-cycle high glitch on `uart_rx` aligned so that `rx_s` is high exactly at the bit-3 decision edge.
  - With `UART_RX_MAJORITY_EN` defined → `rx_byte`=0x00.
  - With the macro undefined → `rx_byte`=0x08.

Source files
------------

// File: rtl/uart_receiver.sv
// 8N1 serial receiver: two-flop synchronizer, bit-period counter, one-cycle byte/error strobes.
// Optional build macro UART_RX_MAJORITY_EN selects 3-sample majority voting at each decision point.
module uart_receiver #(
    parameter int comm_clk_frequency = 50_000_000,
    parameter int baud_rate          = 115_200
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       uart_rx,
    output logic [7:0] rx_byte,
    output logic       rx_new_byte,
    output logic       rx_frame_error,
    output logic       rx_idle
);

    localparam int CYCLES = comm_clk_frequency / baud_rate;
    localparam int HALF   = CYCLES / 2;
    localparam int CNT_W  = ($clog2(CYCLES) > 16) ? $clog2(CYCLES) : 16;

    generate
        if (CYCLES < 4) begin : g_bad_rate
            $error("uart_receiver: comm_clk_frequency / baud_rate must be at least 4");
        end
    endgenerate

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic               r_sync1;
    logic               r_sync2;
    logic               w_rx_s;
    logic               w_rx_v;
    logic [1:0]         r_warm;
    logic               r_armed;
    logic [CNT_W-1:0]   r_cnt;
    logic [2:0]         r_idx;
    logic [7:0]         r_shift;
    logic               w_half_hit;
    logic               w_bit_hit;
    logic               w_shift_en;
    logic               w_good;
    logic               w_ferr;

    assign w_rx_s     = r_sync2;
    assign w_half_hit = (r_cnt == CNT_W'(HALF - 1));
    assign w_bit_hit  = (r_cnt == CNT_W'(CYCLES - 1));

    // Synchronizer and arming; r_warm keeps the reset value of the synchronizer from arming the receiver.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_warm  <= 2'b00;
            r_armed <= 1'b0;
        end else begin
            r_sync1 <= uart_rx;
            r_sync2 <= r_sync1;
            r_warm  <= {r_warm[0], 1'b1};
            r_armed <= r_armed | (r_warm[1] & w_rx_s);
        end
    end

`ifdef UART_RX_MAJORITY_EN
    logic [2:0] r_hist;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_hist <= 3'b111;
        end else begin
            r_hist <= {r_hist[1:0], w_rx_s};
        end
    end

    assign w_rx_v = (r_hist[0] & r_hist[1]) | (r_hist[0] & r_hist[2]) | (r_hist[1] & r_hist[2]);
`else
    assign w_rx_v = w_rx_s;
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Start detection always looks at the raw synchronized line, never the voted value.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (r_armed && !w_rx_s) w_next = S_START;
            S_START: if (w_half_hit) w_next = w_rx_v ? S_IDLE : S_DATA;
            S_DATA:  if (w_bit_hit && (r_idx == 3'd7)) w_next = S_STOP;
            S_STOP:  if (w_bit_hit) w_next = w_rx_v ? S_IDLE : S_BREAK;
            S_BREAK: if (w_rx_s) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        rx_idle    = (r_state == S_IDLE);
        w_shift_en = (r_state == S_DATA) && w_bit_hit;
        w_good     = (r_state == S_STOP) && w_bit_hit && w_rx_v;
        w_ferr     = (r_state == S_STOP) && w_bit_hit && !w_rx_v;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_cnt          <= '0;
            r_idx          <= 3'd0;
            r_shift        <= 8'h00;
            rx_byte        <= 8'h00;
            rx_new_byte    <= 1'b0;
            rx_frame_error <= 1'b0;
        end else begin
            rx_new_byte    <= w_good;
            rx_frame_error <= w_ferr;
            if (w_good) begin
                rx_byte <= r_shift;
            end

            case (r_state)
                S_START: r_cnt <= w_half_hit ? '0 : r_cnt + 1'b1;
                S_DATA,
                S_STOP:  r_cnt <= w_bit_hit ? '0 : r_cnt + 1'b1;
                default: r_cnt <= '0;
            endcase

            if ((r_state == S_START) && w_half_hit) begin
                r_idx <= 3'd0;
            end else if (w_shift_en) begin
                r_idx <= r_idx + 3'd1;
            end

            // LSB arrives first, so shift in from the top.
            if (w_shift_en) begin
                r_shift <= {w_rx_v, r_shift[7:1]};
            end
        end
    end

endmodule

// File: tb/tb_uart_receiver.sv
// Directed bench for uart_receiver at CYCLES=16: an event schedule of expected strobes is checked every cycle.
module tb_uart_receiver;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       uart_rx = 1'b1;
    logic [7:0] rx_byte;
    logic       rx_new_byte;
    logic       rx_frame_error;
    logic       rx_idle;

    uart_receiver #(
        .comm_clk_frequency(1_600_000),
        .baud_rate         (100_000)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .uart_rx       (uart_rx),
        .rx_byte       (rx_byte),
        .rx_new_byte   (rx_new_byte),
        .rx_frame_error(rx_frame_error),
        .rx_idle       (rx_idle)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    logic rst_q = 1'b0;
    always @(posedge clk) begin
        cyc   <= cyc + 1;
        rst_q <= reset;
    end

    int         n_cmp = 0;
    int         n_fail = 0;
    bit         chk_en = 1'b0;
    logic [7:0] exp_byte = 8'h00;
    bit         exp_nb[int];
    logic [7:0] exp_val[int];
    bit         exp_fe[int];
    int         nb_cycles[$];
    int         fe_seen = 0;
    logic       e_nb;
    logic       e_fe;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Model: a frame whose line goes low just after edge k is decided at edge k+1+154.
    always @(negedge clk) begin
        if (chk_en) begin
            if (!rst_q) exp_byte = 8'h00;
            e_nb = exp_nb.exists(cyc);
            e_fe = exp_fe.exists(cyc);
            if (e_nb) exp_byte = exp_val[cyc];
            check("rx_new_byte", {31'd0, rx_new_byte}, {31'd0, e_nb});
            check("rx_frame_error", {31'd0, rx_frame_error}, {31'd0, e_fe});
            check("rx_byte", {24'd0, rx_byte}, {24'd0, exp_byte});
            if (rx_new_byte) nb_cycles.push_back(cyc);
            if (rx_frame_error) fe_seen++;
        end
    end

    task automatic hold(input logic v, input int n);
        uart_rx = v;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b, input logic stop);
        int k;
        k = cyc;
        if (stop) begin
            exp_nb[k + 155]  = 1'b1;
            exp_val[k + 155] = b;
        end else begin
            exp_fe[k + 155] = 1'b1;
        end
        hold(1'b0, 16);
        for (int i = 0; i < 8; i++) hold(b[i], 16);
        hold(stop, 16);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int         k;
        logic [7:0] m;

        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_idle", {31'd0, rx_idle}, 32'd1);
        check("reset_byte", {24'd0, rx_byte}, 32'h00);
        check("reset_nb", {31'd0, rx_new_byte}, 32'd0);
        check("reset_fe", {31'd0, rx_frame_error}, 32'd0);
        reset = 1'b1;
        chk_en = 1'b1;
        hold(1'b1, 10);

        k = cyc;
        send(8'hA5, 1'b1);
        hold(1'b1, 10);
        check("single_val", {24'd0, rx_byte}, 32'hA5);
        check("single_count", nb_cycles.size(), 32'd1);
        check("single_lat", nb_cycles[0] - k, 32'd155);

        send(8'h00, 1'b1);
        send(8'hFF, 1'b1);
        hold(1'b1, 10);
        check("b2b_count", nb_cycles.size(), 32'd3);
        check("b2b_gap", nb_cycles[2] - nb_cycles[1], 32'd160);
        check("b2b_val", {24'd0, rx_byte}, 32'hFF);

        send(8'h3C, 1'b0);
        hold(1'b0, 50);
        check("break_idle", {31'd0, rx_idle}, 32'd0);
        check("ferr_keep", {24'd0, rx_byte}, 32'hFF);
        check("ferr_count", fe_seen, 32'd1);
        hold(1'b1, 20);
        check("break_exit", {31'd0, rx_idle}, 32'd1);
        send(8'h55, 1'b1);
        hold(1'b1, 10);
        check("after_break", {24'd0, rx_byte}, 32'h55);

        hold(1'b0, 4);
        hold(1'b1, 2);
        check("glitch_start", {31'd0, rx_idle}, 32'd0);
        hold(1'b1, 10);
        check("glitch_idle", {31'd0, rx_idle}, 32'd1);
        check("glitch_count", nb_cycles.size(), 32'd4);

        hold(1'b0, 16);
        hold(1'b0, 68);
        reset = 1'b0;
        hold(1'b0, 3);
        reset = 1'b1;
        hold(1'b0, 57);
        hold(1'b1, 16);
        hold(1'b1, 20);
        check("rst_byte", {24'd0, rx_byte}, 32'h00);
        check("rst_nb_count", nb_cycles.size(), 32'd4);
        check("rst_fe_count", fe_seen, 32'd1);
        send(8'h81, 1'b1);
        hold(1'b1, 10);
        check("post_rst", {24'd0, rx_byte}, 32'h81);

        // rx_s is high only in the cycle ending at the bit-3 decision edge (k+75).
`ifdef UART_RX_MAJORITY_EN
        m = 8'h00;
`else
        m = 8'h08;
`endif
        k = cyc;
        exp_nb[k + 155]  = 1'b1;
        exp_val[k + 155] = m;
        hold(1'b0, 16);
        hold(1'b0, 48);
        hold(1'b0, 8);
        hold(1'b1, 1);
        hold(1'b0, 7);
        hold(1'b0, 64);
        hold(1'b1, 16);
        hold(1'b1, 10);
        check("majority", {24'd0, rx_byte}, {24'd0, m});

        check("total_bytes", nb_cycles.size(), 32'd6);
        check("total_ferr", fe_seen, 32'd1);

        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
